// File: rtl/checker_pkg.sv
// Shared types and default markers for the store checker.
// Imported by store_checker and store_match.
package checker_pkg;

  typedef enum logic [2:0] {
    ST_LOAD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_DONE    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  localparam int unsigned DEF_DONE_ADR   = 96;
  localparam int unsigned DEF_DONE_DATA  = 30;
  localparam int unsigned DEF_IGNORE_ADR = 164;

endpackage

// File: rtl/store_match.sv
// Address compare plus byte-lane masked data compare
// of one observed store against one table entry.
module store_match
  import checker_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]   adr,
  input  logic [DATA_W-1:0]   data,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   exp_adr,
  input  logic [DATA_W-1:0]   exp_data,
  output logic                match
);

  logic [DATA_W-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < DATA_W / 8; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
  end

  assign match = (adr == exp_adr) &&
                 (((data ^ exp_data) & mask) == '0);

endmodule

// File: rtl/store_checker.sv
// Scores an observed store bus against a loaded table
// of expected stores; ends in DONE, FAIL or TIMEOUT.
module store_checker
  import checker_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 32,
  parameter int          NUM_CHECKS  = 32,
  parameter bit          IN_ORDER    = 1'b0,
  parameter int unsigned DONE_ADR    = DEF_DONE_ADR,
  parameter int unsigned DONE_DATA   = DEF_DONE_DATA,
  parameter int unsigned IGNORE_ADR  = DEF_IGNORE_ADR,
  parameter int unsigned TIMEOUT_CYC = 100000,
  localparam int IDX_W = $clog2(NUM_CHECKS),
  localparam int CNT_W = $clog2(NUM_CHECKS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_write,
  input  logic [ADDR_W-1:0]   data_adr,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [DATA_W/8-1:0] byte_enable,
  input  logic                exp_we,
  input  logic [IDX_W-1:0]    exp_idx,
  input  logic [ADDR_W-1:0]   exp_adr,
  input  logic [DATA_W-1:0]   exp_data,
  input  logic                start,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    pass_count,
  output logic                all_passed,
  output logic [ADDR_W-1:0]   fail_adr,
  output logic [DATA_W-1:0]   fail_data
);

  localparam int CYC_W = $clog2(TIMEOUT_CYC + 1);

  state_t st, nst;

  logic [NUM_CHECKS-1:0] valid, hit, eq, elig;
  logic [ADDR_W-1:0]     tadr [NUM_CHECKS];
  logic [DATA_W-1:0]     tdat [NUM_CHECKS];
  logic [CYC_W-1:0]      cyc;
  logic [CNT_W-1:0]      ptr, nvalid;
  logic [IDX_W-1:0]      match_idx;
  logic                  match_any, ptr_ok;
  logic                  is_done, do_match, do_fail;
  int                    eff;

  for (genvar g = 0; g < NUM_CHECKS; g++) begin : g_m
    store_match #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_m (
      .adr     (data_adr),
      .data    (write_data),
      .be      (byte_enable),
      .exp_adr (tadr[g]),
      .exp_data(tdat[g]),
      .match   (eq[g])
    );
  end

  // In-order mode: eligible entry is first valid one at/after ptr
  always_comb begin
    eff = 0;
    ptr_ok = 1'b0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (valid[i] && i >= int'(ptr)) begin
        eff = i;
        ptr_ok = 1'b1;
      end
    end
  end

  always_comb begin
    elig = '0;
    match_any = 1'b0;
    match_idx = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      elig[i] = valid[i] & ~hit[i] & eq[i] &
                (!IN_ORDER || (ptr_ok && i == eff));
    end
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (elig[i]) begin
        match_any = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

  assign nvalid  = CNT_W'($countones(valid));
  assign is_done = (data_adr == ADDR_W'(DONE_ADR)) &&
                   (write_data == DATA_W'(DONE_DATA));

  always_comb begin
    nst = st;
    do_match = 1'b0;
    do_fail = 1'b0;
    unique case (st)
      ST_LOAD: if (start) nst = ST_RUN;
      ST_RUN: begin
        if (mem_write && is_done) begin
          nst = ST_DONE;
        end else begin
          if (mem_write && match_any) begin
            do_match = 1'b1;
          end else if (mem_write &&
                       data_adr != ADDR_W'(IGNORE_ADR)) begin
            do_fail = 1'b1;
            nst = ST_FAIL;
          end
          if (!do_fail &&
              cyc == CYC_W'(TIMEOUT_CYC - 1))
            nst = ST_TIMEOUT;
        end
      end
      default: nst = st;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st         <= ST_LOAD;
      valid      <= '0;
      hit        <= '0;
      pass_count <= '0;
      all_passed <= 1'b0;
      fail_adr   <= '0;
      fail_data  <= '0;
      cyc        <= '0;
      ptr        <= '0;
    end else begin
      st <= nst;
      if (st == ST_LOAD && exp_we) begin
        valid[exp_idx] <= 1'b1;
        hit[exp_idx]   <= 1'b0;
        tadr[exp_idx]  <= exp_adr;
        tdat[exp_idx]  <= exp_data;
      end
      if (st == ST_RUN) cyc <= cyc + 1'b1;
      if (do_match) begin
        hit[match_idx] <= 1'b1;
        if (pass_count != CNT_W'(NUM_CHECKS))
          pass_count <= pass_count + 1'b1;
        if (IN_ORDER) ptr <= CNT_W'(eff + 1);
      end
      if (do_fail) begin
        fail_adr  <= data_adr;
        fail_data <= write_data;
      end
      if (st == ST_RUN && nst == ST_DONE)
        all_passed <= (pass_count == nvalid);
    end
  end

  assign state = st;

endmodule

// File: doc/store_checker.md
STORE_CHECKER -- requirements
Module: store_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 32, store data width (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 32, store address width.
REQ-003 SHALL have parameter NUM_CHECKS, default 32, number of expected-store entries.
REQ-004 SHALL have parameter IN_ORDER, default 0; 1 = stores must match entries in index order, 0 = any order.
REQ-005 SHALL have parameters DONE_ADR/DONE_DATA, defaults 96/30, end-of-test store marker.
REQ-006 SHALL have parameters IGNORE_ADR, default 164, and TIMEOUT_CYC, default 100000.
REQ-007 SHALL have ports: clk  input  1  rising-edge clock.
REQ-008 SHALL have ports: reset  input  1  synchronous, active-low reset.
REQ-009 SHALL have ports: mem_write  input  1; data_adr  input  ADDR_W; write_data  input  DATA_W; byte_enable  input  DATA_W/8. These are the observed store bus.
REQ-010 SHALL have ports: exp_we  input  1; exp_idx  input  clog2(NUM_CHECKS); exp_adr  input  ADDR_W; exp_data  input  DATA_W. These form the table load port.
REQ-011 SHALL have ports: start  input  1  LOAD->RUN.
REQ-012 SHALL have outputs: state  output  3; pass_count  output  clog2(NUM_CHECKS+1); all_passed  output  1; fail_adr  output  ADDR_W; fail_data  output  DATA_W.

Function
REQ-013 SHALL implement FSM states LOAD, RUN, DONE, FAIL, TIMEOUT; DONE/FAIL/TIMEOUT sticky until reset.
REQ-014 In LOAD, exp_we SHALL write entry exp_idx {valid=1, hit=0, adr, data}; mem_write ignored.
REQ-015 start in LOAD SHALL enter RUN next cycle; exp_we in the same cycle SHALL still be written; start outside LOAD ignored.
REQ-016 In RUN, mem_write with data_adr==DONE_ADR and write_data==DONE_DATA SHALL enter DONE; this check has priority over the table.
REQ-017 Otherwise the store SHALL match the lowest-index entry that is valid, not hit, equal in address, and equal in data on enabled bytes only (byte_enable lane i gates bits 8i+7:8i).
REQ-018 With IN_ORDER=1, only the entry at the order pointer SHALL be eligible; the pointer advances past invalid entries.
REQ-019 A match SHALL set that entry's hit bit and increment pass_count by 1.
REQ-020 A non-matching store with data_adr!=IGNORE_ADR SHALL enter FAIL and capture data_adr/write_data into fail_adr/fail_data.
REQ-021 A non-matching store to IGNORE_ADR SHALL have no effect.
REQ-022 A cycle counter SHALL run only in RUN and enter TIMEOUT when it reaches TIMEOUT_CYC-1 without DONE/FAIL.
REQ-023 If DONE and timeout occur in the same cycle, DONE SHALL win.
REQ-024 all_passed SHALL be 1 only in DONE with pass_count equal to the number of valid entries.
REQ-025 All outputs SHALL be registered; a store sampled at edge N SHALL be reflected at edge N+1.
REQ-026 pass_count SHALL saturate at NUM_CHECKS.
REQ-027 Duplicate (adr,data) entries SHALL each be matchable once.

Reset
REQ-028 While reset=0 at a clk edge: state=LOAD, all valid/hit=0, pass_count=0, all_passed=0, fail_adr=0, fail_data=0, cycle counter=0, order pointer=0.
REQ-029 Reset asserted mid-RUN SHALL discard the loaded table.

Structure
REQ-030 State encoding and the DONE/IGNORE defaults SHALL live in shared package checker_pkg.
REQ-031 Masked address/data comparison of one entry SHALL be sub-module store_match, instantiated NUM_CHECKS times; the priority pick SHALL stay in store_checker.

Verification
REQ-032 Load {100,25},{104,4096}; start; store 100/25, 104/4096, 96/30 -> DONE, pass_count=2, all_passed=1.
REQ-033 Load {100,25}; start; store 100/26 -> FAIL, fail_adr=100, fail_data=26, pass_count=0.
REQ-034 IN_ORDER=1, load idx0 {100,25}, idx1 {104,9}; store 104/9 first -> FAIL; IN_ORDER=0 same stimulus -> pass_count=1.
REQ-035 Load {100,25},{100,-154}; store 100/-154 then 100/25 -> pass_count=2; third 100/25 -> FAIL.
REQ-036 Store 164/any -> no change; byte_enable=4'b0001 store 120/0x0000_0000 against entry {120,0xFFFF_FF00} -> match.
REQ-037 TIMEOUT_CYC=16, start, no stores -> TIMEOUT 16 cycles after RUN; reset=0 mid-RUN -> LOAD, pass_count=0.
